// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the fetch/data RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STREAK_W   = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decision between fetch and data ports, plus the
// next value of the data-streak fairness counter.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic                i_en,
  input  logic                i_if_req,
  input  logic                i_d_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_if_gnt_c,
  output logic                o_d_gnt_c,
  output logic [STREAK_W-1:0] o_streak_nxt_c
);

  logic w_d_wins;

  // Data wins a conflict only while fetch has not yet waited the full streak.
  assign w_d_wins = !i_if_req || (i_streak < STREAK_W'(MAX_D_STREAK));

  always_comb begin
    o_if_gnt_c = 1'b0;
    o_d_gnt_c  = 1'b0;
    if (i_en) begin
      if (i_d_req && w_d_wins) begin
        o_d_gnt_c = 1'b1;
      end else if (i_if_req) begin
        o_if_gnt_c = 1'b1;
      end
    end
  end

  always_comb begin
    o_streak_nxt_c = i_streak;
    if (!i_if_req || o_if_gnt_c) begin
      o_streak_nxt_c = '0;
    end else if (o_d_gnt_c) begin
      o_streak_nxt_c = i_streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between fetch and load/store,
// steering the one-cycle-late read data back to the previous grant owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_nxt;
  owner_e              r_owner;
  owner_e              w_owner_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [DATA_W-1:0]   r_if_hold;
  logic [DATA_W-1:0]   r_d_hold;
  logic                w_if_gnt;
  logic                w_d_gnt;
  logic                w_unused;

  mem_arb_grant #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_grant (
    .i_en           (rst_n),
    .i_if_req       (if_req),
    .i_d_req        (d_req),
    .i_streak       (r_streak),
    .o_if_gnt_c     (w_if_gnt),
    .o_d_gnt_c      (w_d_gnt),
    .o_streak_nxt_c (w_streak_nxt)
  );

  // Word address of the winner; upper byte-address bits alias by design.
  assign w_gnt_addr = w_d_gnt ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
  assign w_unused   = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                        d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_d_gnt) begin
      w_owner_nxt = d_we ? OWN_D_WR : OWN_D_RD;
    end else if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak  <= '0;
      r_owner   <= OWN_NONE;
      r_addr    <= '0;
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      r_streak <= w_streak_nxt;
      r_owner  <= w_owner_nxt;
      if (w_if_gnt || w_d_gnt) begin
        r_addr <= w_gnt_addr;
      end
      if (r_owner == OWN_IF) begin
        r_if_hold <= ram_dout;
      end
      if (r_owner == OWN_D_RD) begin
        r_d_hold <= ram_dout;
      end
    end
  end

  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;
  assign ram_we   = w_d_gnt & d_we;
  assign ram_din  = d_wdata;
  assign ram_addr = (w_if_gnt || w_d_gnt) ? w_gnt_addr : r_addr;

  assign if_valid = (r_owner == OWN_IF);
  assign d_valid  = (r_owner == OWN_D_RD) || (r_owner == OWN_D_WR);
  assign if_rdata = (r_owner == OWN_IF)   ? ram_dout : r_if_hold;
  assign d_rdata  = (r_owner == OWN_D_RD) ? ram_dout : r_d_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1024x32 RAM beside it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:1023];
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (10),
    .DATA_W       (32),
    .MAX_D_STREAK (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = v;
  endtask

  initial begin
    rst_n = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    preload(10'd0, 32'h11);
    preload(10'd1, 32'h22);
    preload(10'd2, 32'h33);
    preload(10'd8, 32'hCAFE0001);
    @(negedge clk);
    pl_we = 1'b0;

    // reset state, with both requesters active
    drive(1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'h5);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fetch-only stream
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f0_gnt", 32'(if_gnt), 32'd1);
    chk("f0_addr", 32'(ram_addr), 32'd0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f1_gnt", 32'(if_gnt), 32'd1);
    chk("f1_addr", 32'(ram_addr), 32'd1);
    chk("f0_valid", 32'(if_valid), 32'd1);
    chk("f0_rdata", if_rdata, 32'h11);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f2_gnt", 32'(if_gnt), 32'd1);
    chk("f1_rdata", if_rdata, 32'h22);
    idle();
    chk("idle_if_gnt", 32'(if_gnt), 32'd0);
    chk("idle_addr_hold", 32'(ram_addr), 32'd2);
    chk("f2_valid", 32'(if_valid), 32'd1);
    chk("f2_rdata", if_rdata, 32'h33);
    idle();
    chk("idle_if_valid", 32'(if_valid), 32'd0);
    chk("idle_if_hold", if_rdata, 32'h33);

    // store then fetch of the same word
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("st_gnt", 32'(d_gnt), 32'd1);
    chk("st_we", 32'(ram_we), 32'd1);
    chk("st_addr", 32'(ram_addr), 32'd4);
    chk("st_din", ram_din, 32'hDEADBEEF);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("st_ack", 32'(d_valid), 32'd1);
    chk("st_rdata_hold", d_rdata, 32'd0);
    chk("raw_if_gnt", 32'(if_gnt), 32'd1);
    chk("raw_we", 32'(ram_we), 32'd0);
    idle();
    chk("raw_valid", 32'(if_valid), 32'd1);
    chk("raw_rdata", if_rdata, 32'hDEADBEEF);
    chk("raw_d_valid", 32'(d_valid), 32'd0);

    // both requesting: D, D, IF, D, D, IF
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
      chk($sformatf("arb%0d_d_gnt", i), 32'(d_gnt), (i % 3 != 2) ? 32'd1 : 32'd0);
      chk($sformatf("arb%0d_if_gnt", i), 32'(if_gnt), (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i > 0) begin
        if ((i - 1) % 3 != 2) begin
          chk($sformatf("arb%0d_d_valid", i), 32'(d_valid), 32'd1);
          chk($sformatf("arb%0d_d_rdata", i), d_rdata, 32'h11);
          chk($sformatf("arb%0d_if_valid", i), 32'(if_valid), 32'd0);
        end else begin
          chk($sformatf("arb%0d_if_valid", i), 32'(if_valid), 32'd1);
          chk($sformatf("arb%0d_if_rdata", i), if_rdata, 32'h22);
          chk($sformatf("arb%0d_d_valid", i), 32'(d_valid), 32'd0);
        end
      end
    end
    idle();
    chk("arb_last_if_valid", 32'(if_valid), 32'd1);
    chk("arb_last_if_rdata", if_rdata, 32'h22);

    // single load, then hold
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("ld_gnt", 32'(d_gnt), 32'd1);
    chk("ld_we", 32'(ram_we), 32'd0);
    idle();
    chk("ld_valid", 32'(d_valid), 32'd1);
    chk("ld_rdata", d_rdata, 32'hCAFE0001);
    idle();
    chk("ld_valid_once", 32'(d_valid), 32'd0);
    chk("ld_hold", d_rdata, 32'hCAFE0001);

    // reset right after a fetch grant drops the response
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mr_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_if_valid", 32'(if_valid), 32'd0);
    chk("mr_if_gnt", 32'(if_gnt), 32'd0);
    chk("mr_if_rdata", if_rdata, 32'd0);
    chk("mr_d_rdata", d_rdata, 32'd0);
    chk("mr_ram_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if_req = 1'b0;
    idle();
    chk("mr_post_if_valid", 32'(if_valid), 32'd0);
    chk("mr_post_d_valid", 32'(d_valid), 32'd0);
    chk("mr_post_if_rdata", if_rdata, 32'd0);

    // upper address bits alias, low bits dropped
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("al_pre_addr", 32'(ram_addr), 32'd2);
    drive(1'b1, 32'h1003, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("al_addr", 32'(ram_addr), 32'd0);
    chk("al_pre_rdata", if_rdata, 32'h33);
    idle();
    chk("al_rdata", if_rdata, 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port synchronous instruction/data RAM (1024 x 32, one-cycle read latency) between the fetch stage and the load/store stage of the MIPS core. Each cycle it grants at most one requester and drives the RAM address, write enable and write data. It then routes the returned word back to the owner of the previous grant with a valid strobe. Data-port priority is bounded by a fairness counter so fetch can never starve.

## Interface
- `ADDR_W`, 10: RAM word-address width; byte address bits `[ADDR_W+1:2]` are used.
- `DATA_W`, 32: word width.
- `MAX_D_STREAK`, 2: maximum consecutive data grants while fetch is waiting; range 1..7.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held with stable `if_addr` until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: combinational grant of `if_req` this cycle.
- `if_valid` out 1: fetch word on `if_rdata` this cycle.
- `if_rdata` out DATA_W: fetched word.
- `d_req` in 1: data request; held with stable `d_we`, `d_addr` and `d_wdata` until `d_gnt`.
- `d_we` in 1: 1 for store, 0 for load.
- `d_addr` in 32: data byte address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: combinational grant of `d_req`.
- `d_valid` out 1: load data is valid, or store acknowledged.
- `d_rdata` out DATA_W: load word.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_din` out DATA_W: RAM write data.
- `ram_dout` in DATA_W: RAM read data, valid one cycle after its address.

## Operation
- Grant rules, evaluated combinationally each cycle:
  - Only one requester asserted: that requester is granted.
  - Both asserted and `streak < MAX_D_STREAK`: data is granted.
  - Both asserted and `streak == MAX_D_STREAK`: fetch is granted.
  - Neither asserted: no grant; `ram_we=0`; `ram_addr` holds its last value.
- Streak counter, 3 bits:
  - Increments on a data grant while `if_req=1`.
  - Clears on a fetch grant, and on any cycle with `if_req=0`.
- `ram_addr` takes the granted requester's address bits `[ADDR_W+1:2]`. Upper bits alias and bits `[1:0]` are ignored; no misalignment error.
- `ram_we = d_gnt & d_we`; `ram_din = d_wdata`.
- Return-path owner register with states NONE, IF, D_RD, D_WR; it loads the grant type each cycle.
  - Next cycle, owner IF: `if_valid=1`, `if_rdata=ram_dout`.
  - Next cycle, owner D_RD: `d_valid=1`, `d_rdata=ram_dout`.
  - Next cycle, owner D_WR: `d_valid=1`; `d_rdata` keeps its held value.
  - Next cycle, owner NONE: no valid strobe.
- When not valid, each `*_rdata` holds the last word it delivered. Holding registers load on valid.

## Timing
- Grant is same-cycle. Read data and store acknowledge arrive exactly 1 cycle after the grant.
- Throughput is one access per cycle. Back-to-back grants to the same or alternating requesters are legal.
- Store followed by a fetch from the same address in the next cycle returns the new word.
- Reset values:
  - streak = 0, owner = NONE.
  - `if_valid`, `d_valid`, `if_rdata`, `d_rdata`, `ram_addr` all 0.
  - `ram_we` is 0 while `rst_n=0`.
- Reset asserted mid-access: the in-flight response is dropped, with no valid strobe after release. Grants are suppressed while `rst_n=0`.
- A request dropped before its grant is legal and leaves no state behind.

## Structure
- Shared package `mem_arb_pkg`:
  - owner enum {NONE, IF, D_RD, D_WR}.
  - `ADDR_W`/`DATA_W` defaults.
  - `STREAK_W = 3`.
- One sub-module, `mem_arb_grant`: purely combinational grant decision plus streak next-state logic. The owner register, holding registers and RAM muxing live in the top module.
- The RAM itself stays outside this block; it is instantiated beside the arbiter in the core top.

## Test plan
- Fetch only, `if_addr` = 0x0, 0x4, 0x8 on consecutive cycles, RAM preloaded with 0x11, 0x22, 0x33 -> `if_gnt` each cycle; `if_valid` with 0x11, 0x22, 0x33 one cycle later.
- `d_req` with `d_we=1`, `d_addr=0x10`, `d_wdata=0xDEADBEEF`, then a fetch of 0x10 next cycle -> `d_valid` in cycle 1; `if_rdata=0xDEADBEEF` in cycle 2.
- Both requesting continuously, `MAX_D_STREAK=2` -> grant sequence D, D, IF, D, D, IF; streak reads 0, 1, 2, 0, 1, 2.
- Load of 0x20 (contents 0xCAFE0001) with no later traffic -> `d_valid` pulses once; `d_rdata` holds 0xCAFE0001 afterwards.
- `rst_n` pulled low the cycle after a fetch grant -> no `if_valid`; all outputs 0 during and after reset until the next grant.
- `if_addr=0x1003` with `ADDR_W=10` -> `ram_addr=0x000` (aliasing, low bits dropped).
